// File: rtl/hack_loader_pkg.sv
// hack_loader_pkg: shared definitions for the Hack serial program loader.
//   - loader FSM and byte-receiver state encodings
//   - default clock/baud constants and the derived CLKS_PER_BIT
//   - helpers for bit timing and the maximum loadable word count
package hack_loader_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT   = 115_200;
    localparam int CLKS_PER_BIT   = CLK_HZ_DEFAULT / BAUD_DEFAULT;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clock cycles per serial bit (integer division).
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Largest legal word count: the whole instruction memory, 2^addr_w words.
    // 17 bits so that a 16-bit address space still fits.
    function automatic logic [16:0] count_limit(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

endpackage

// File: rtl/hack_program_loader_uart_rx.sv
// uart_rx: 8N1 byte receiver.
//   clk, reset     : system clock, async active-high reset
//   rx             : raw serial line, idle high, asynchronous to clk
//   byte_valid     : one-cycle pulse when a frame completes
//   byte_data[7:0] : received byte (LSB first on the wire)
//   frame_err      : stop bit sampled low for the frame in byte_data
module uart_rx
    import hack_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     st;
    logic [CW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        st   <= RX_START;
                        tick <= '0;
                    end
                end
                // Half a bit in: line back high means the "start" was a glitch.
                RX_START: begin
                    if (tick == HALF_M1) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        st      <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                // Tick is now aligned to bit centres.
                RX_DATA: begin
                    if (tick == FULL_M1) begin
                        tick  <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) st <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick == FULL_M1) begin
                        tick       <= '0;
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                        frame_err  <= !rx_sync;
                        st         <= RX_IDLE;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hack_program_loader.sv
// hack_program_loader: loads the Hack instruction memory over UART.
// Protocol: 16-bit word count then that many 16-bit instructions, MSB byte
// first; words go to consecutive addresses from 0.
//   clk, reset : system clock, async active-high reset
//   rx         : UART receive line (8N1, idle high)
//   rom_we     : one-cycle instruction memory write strobe
//   rom_addr   : write address
//   rom_data   : instruction word to write
//   cpu_hold   : keeps the CPU in reset during a load and after an error
//   busy       : load in progress
//   done       : last load completed
//   error      : last load aborted (bad count, framing error or timeout)
module hack_program_loader
    import hack_loader_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BAUD           = 115_200,
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int            CPB   = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam logic [16:0]   LIMIT = count_limit(ADDR_W);
    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    logic          byte_valid, frame_err;
    logic [7:0]    byte_data;
    loader_state_t state, state_n;
    logic [15:0]   count, cnt_full;
    logic [TW-1:0] tcnt;
    logic          busy_st, timeout, accept, last_word;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign busy_st   = state inside {CNT_LO, DATA_HI, DATA_LO, WRITE};
    assign timeout   = busy_st && (tcnt == TMAX);
    assign accept    = byte_valid && !frame_err;
    assign cnt_full  = {count[15:8], byte_data};
    assign last_word = 17'(rom_addr) == (17'(count) - 17'd1);

    always_comb begin
        state_n = state;
        case (state)
            // A bad frame while idle/done is noise and ignored; in ERROR we
            // stay put anyway. Only a clean byte starts a new load.
            IDLE, CNT_HI, DONE, ERROR: if (accept) state_n = CNT_LO;
            CNT_LO: begin
                if (byte_valid) begin
                    if (frame_err)                        state_n = ERROR;
                    else if (cnt_full == 16'd0)           state_n = DONE;
                    else if ({1'b0, cnt_full} > LIMIT)    state_n = ERROR;
                    else                                  state_n = DATA_HI;
                end
            end
            DATA_HI: if (byte_valid) state_n = frame_err ? ERROR : DATA_LO;
            DATA_LO: if (byte_valid) state_n = frame_err ? ERROR : WRITE;
            WRITE:   state_n = last_word ? DONE : DATA_HI;
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = ERROR;
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            tcnt     <= '0;
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            rom_we   <= (state_n == WRITE);
            cpu_hold <= state_n inside {CNT_LO, DATA_HI, DATA_LO, WRITE, ERROR};
            busy     <= state_n inside {CNT_LO, DATA_HI, DATA_LO, WRITE};
            done     <= (state_n == DONE);
            error    <= (state_n == ERROR);

            if (!busy_st || byte_valid) tcnt <= '0;
            else if (tcnt != TMAX)      tcnt <= tcnt + TW'(1);

            if (accept && !timeout) begin
                case (state)
                    IDLE, CNT_HI, DONE, ERROR: count[15:8] <= byte_data;
                    CNT_LO: begin
                        count[7:0] <= byte_data;
                        rom_addr   <= '0;
                    end
                    DATA_HI: rom_data[15:8] <= byte_data;
                    DATA_LO: rom_data[7:0]  <= byte_data;
                    default: ;
                endcase
            end

            // The count check bounds rom_addr, so this increment never wraps.
            if (state == WRITE && state_n == DATA_HI)
                rom_addr <= rom_addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_hack_program_loader.sv
module tb_hack_program_loader;

    localparam int BIT = 16;  // 1600 Hz / 100 baud

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_hold, busy, done, error;

    int checks = 0;
    int failures = 0;

    logic [14:0] wa [0:63];
    logic [15:0] wd [0:63];
    int          wr_total = 0;

    hack_program_loader #(
        .CLK_HZ(1600), .BAUD(100), .ADDR_W(15), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_we) begin
            if (wr_total < 64) begin
                wa[wr_total] = rom_addr;
                wd[wr_total] = rom_data;
            end
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_we",   32'(rom_we),   0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_data", 32'(rom_data), 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_busy", 32'(busy),     0);
        chk("rst_done", 32'(done),     0);
        chk("rst_err",  32'(error),    0);

        // Scenario 1: two words
        base = wr_total;
        send_byte(8'h00, 1'b1);
        settle();
        chk("s1_hold_cnt", 32'(cpu_hold), 1);
        chk("s1_busy_cnt", 32'(busy),     1);
        send_byte(8'h02, 1'b1);
        send_word(16'hABCD);
        send_word(16'h1234);
        settle();
        chk("s1_nwr",   32'(wr_total - base), 2);
        chk("s1_a0",    32'(wa[base]),        0);
        chk("s1_d0",    32'(wd[base]),        32'hABCD);
        chk("s1_a1",    32'(wa[base+1]),      1);
        chk("s1_d1",    32'(wd[base+1]),      32'h1234);
        chk("s1_done",  32'(done),            1);
        chk("s1_hold",  32'(cpu_hold),        0);
        chk("s1_busy",  32'(busy),            0);

        // Scenario 2: empty program
        base = wr_total;
        send_word(16'h0000);
        settle();
        chk("s2_nwr",  32'(wr_total - base), 0);
        chk("s2_done", 32'(done),            1);
        chk("s2_hold", 32'(cpu_hold),        0);
        chk("s2_err",  32'(error),           0);

        // Scenario 3: count exceeds memory
        base = wr_total;
        send_word(16'h8001);
        settle();
        chk("s3_nwr",  32'(wr_total - base), 0);
        chk("s3_err",  32'(error),           1);
        chk("s3_hold", 32'(cpu_hold),        1);
        chk("s3_done", 32'(done),            0);
        chk("s3_busy", 32'(busy),            0);

        // Scenario 4: truncated load then timeout, then recovery
        base = wr_total;
        send_word(16'h0003);
        send_word(16'hABCD);
        send_byte(8'h12, 1'b1);
        settle();
        chk("s4_nwr",     32'(wr_total - base), 1);
        chk("s4_a0",      32'(wa[base]),        0);
        chk("s4_d0",      32'(wd[base]),        32'hABCD);
        chk("s4_err_pre", 32'(error),           0);
        repeat (890) @(posedge clk); #1;
        chk("s4_no_early_to", 32'(error), 0);
        for (int i = 0; i < 300 && !error; i++) begin
            @(posedge clk); #1;
        end
        chk("s4_to_err",  32'(error),    1);
        chk("s4_to_hold", 32'(cpu_hold), 1);
        chk("s4_to_busy", 32'(busy),     0);
        base = wr_total;
        send_word(16'h0001);
        send_word(16'h55AA);
        settle();
        chk("s4_rec_nwr",  32'(wr_total - base), 1);
        chk("s4_rec_a0",   32'(wa[base]),        0);
        chk("s4_rec_d0",   32'(wd[base]),        32'h55AA);
        chk("s4_rec_done", 32'(done),            1);
        chk("s4_rec_err",  32'(error),           0);
        chk("s4_rec_hold", 32'(cpu_hold),        0);

        // Scenario 5: framing error in DATA_HI, then glitch and bad frame in DONE
        base = wr_total;
        send_word(16'h0002);
        send_byte(8'hFF, 1'b0);
        settle();
        chk("s5_fe_err",  32'(error),           1);
        chk("s5_fe_hold", 32'(cpu_hold),        1);
        chk("s5_fe_nwr",  32'(wr_total - base), 0);
        send_word(16'h0000);
        settle();
        chk("s5_done", 32'(done), 1);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (200) @(posedge clk); #1;
        chk("s5_gl_done", 32'(done), 1);
        chk("s5_gl_busy", 32'(busy), 0);
        chk("s5_gl_hold", 32'(cpu_hold), 0);
        send_byte(8'h00, 1'b0);
        settle();
        chk("s5_idlefe_done", 32'(done),  1);
        chk("s5_idlefe_err",  32'(error), 0);
        chk("s5_idlefe_busy", 32'(busy),  0);

        // Scenario 6: reset during DATA_LO with a half-received byte
        base = wr_total;
        send_word(16'h0002);
        send_word(16'hABCD);
        send_byte(8'h11, 1'b1);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("s6_nwr_pre", 32'(wr_total - base), 1);
        chk("s6_we",   32'(rom_we),   0);
        chk("s6_addr", 32'(rom_addr), 0);
        chk("s6_data", 32'(rom_data), 0);
        chk("s6_hold", 32'(cpu_hold), 0);
        chk("s6_busy", 32'(busy),     0);
        chk("s6_done", 32'(done),     0);
        chk("s6_err",  32'(error),    0);
        rx = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        repeat (50) @(posedge clk);
        base = wr_total;
        send_word(16'h0001);
        send_word(16'h1234);
        settle();
        chk("s6_post_nwr",  32'(wr_total - base), 1);
        chk("s6_post_a0",   32'(wa[base]),        0);
        chk("s6_post_d0",   32'(wd[base]),        32'h1234);
        chk("s6_post_done", 32'(done),            1);
        chk("s6_post_hold", 32'(cpu_hold),        0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hack_program_loader.md
Name: hack_program_loader

Overview:
- Serial program loader that fills the Hack instruction memory over UART. It is the writer side of the instruction-memory interface, which the CPU otherwise only reads.
- Receives a word count followed by 16-bit instructions, 8N1, MSB byte first. Writes each instruction to consecutive addresses starting at 0.
- Holds the Hack CPU in reset while a load is in progress.
- Sits in the Basys3 top beside the computer and program memory. The top ORs cpu_hold with the reset button to form the CPU reset.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division
- ADDR_W, 15, instruction memory address width
- TIMEOUT_CYCLES, 10000000, maximum idle clocks between bytes inside a load before abort

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx  in  1  UART receive line, idle high, asynchronous to clk
- rom_we  out  1  one-cycle write strobe to instruction memory
- rom_addr  out  ADDR_W  write address
- rom_data  out  16  instruction word to write
- cpu_hold  out  1  high while a load is in progress or after an error
- busy  out  1  high from first count byte until DONE or ERROR
- done  out  1  high in DONE until the next load starts
- error  out  1  high in ERROR until the next load starts

Behaviour:
- Reset values:
  - rom_we=0, rom_addr=0, rom_data=0
  - cpu_hold=0, busy=0, done=0, error=0
  - state=IDLE
  - byte receiver is idle
- rx synchronisation: rx passes through a 2-flop synchronizer; both flops reset to 1.
- uart_rx sub-block:
  - Start is a falling edge on the synchronized rx.
  - Start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the start is a glitch and the block returns to idle.
  - Data bits are sampled at bit centres, LSB first.
  - The stop bit is sampled at its centre.
  - It then outputs a one-cycle byte_valid pulse with byte_data[7:0] and frame_err (stop bit sampled 0).
- FSM states: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
- Transitions:
  - IDLE/DONE/ERROR: on a valid byte, latch count[15:8] and go to CNT_LO. done and error clear that same cycle.
  - CNT_LO: on a byte, latch count[7:0], set rom_addr=0, then evaluate the count:
    - count==0 -> DONE
    - count > 2^ADDR_W -> ERROR
    - otherwise -> DATA_HI
  - DATA_HI: on a byte, latch rom_data[15:8] -> DATA_LO.
  - DATA_LO: on a byte, latch rom_data[7:0] -> WRITE.
  - WRITE (exactly 1 cycle):
    - rom_we=1 with rom_addr and rom_data stable.
    - Next cycle: if rom_addr==count-1 -> DONE; else rom_addr+1 -> DATA_HI.
- Latency: rom_we asserts the cycle after the byte_valid of the low data byte.
- Outputs by state:
  - cpu_hold = 1 in CNT_LO, DATA_HI, DATA_LO, WRITE, ERROR; 0 in IDLE and DONE.
  - busy = 1 in CNT_LO, DATA_HI, DATA_LO, WRITE.
- Framing error: frame_err on any byte drops that byte and goes to ERROR, from any state. In IDLE/DONE the byte is ignored and the state is unchanged.
- Timeout:
  - A counter clears on every byte_valid and increments while busy.
  - When it reaches TIMEOUT_CYCLES -> ERROR.
  - The timeout is inactive outside busy.
- ERROR: cpu_hold stays high, so partially loaded code never runs. It is left only by a new count byte or by reset.
- Reset mid-load: all state returns to reset values immediately, including the half-received byte. Memory contents already written are left as is.
- rom_addr wraps never: the count check guarantees rom_addr ≤ 2^ADDR_W−1.

Decomposition:
- Shared package hack_loader_pkg holds:
  - FSM state encodings
  - localparam CLKS_PER_BIT = CLK_HZ/BAUD
  - the count-limit constant
- One sub-module, uart_rx: synchronizer, bit-timing counter, shift register, byte_valid/frame_err.

Test Plan:
- Simulation runs with CLK_HZ=1600, BAUD=100 (16 clks/bit) and TIMEOUT_CYCLES=1000.
- Scenario 1: send count 0x0002, words 0xABCD, 0x1234 -> two rom_we pulses, (addr 0, 0xABCD) then (addr 1, 0x1234). cpu_hold=1 from the first count byte's byte_valid until DONE; done=1 and cpu_hold=0 after the second write.
- Scenario 2: count 0x0000 -> no rom_we; done=1; cpu_hold returns to 0 after the count low byte.
- Scenario 3: count 0x8001 (ADDR_W=15) -> ERROR, error=1, cpu_hold=1, no rom_we.
- Scenario 4: count 0x0003, 1.5 words, then silence -> exactly one rom_we (addr 0); after 1000 idle clocks error=1, cpu_hold=1. A fresh count 0x0001 plus one word then gives done=1 and error=0.
- Scenario 5: byte with stop bit 0 during DATA_HI -> ERROR. A 4-clock low glitch on rx in IDLE -> no byte_valid, state unchanged.
- Scenario 6: assert reset during DATA_LO -> all outputs at reset values next cycle. Complete frames sent after release are received correctly.
